unidade_controle_multiciclo: RTL and testbench
==============================================

UNIDADE_CONTROLE_MULTICICLO -- requirements
Module: unidade_controle_multiciclo

Interface
REQ-001 Parameter: NREG, default 8, register-file size; power of 2, range 2..16.
REQ-002 Parameter: RB, default $clog2(NREG), register-field width; instruction width IW = 3 + 2*RB (default 9).
REQ-003 Clock  in  1  single clock; all state updates on rising edge.
REQ-004 Resetn  in  1  asynchronous, active-low reset.
REQ-005 Run  in  1  start request, sampled in IDLE and at the last step of each instruction.
REQ-006 Instrucao  in  IW  instruction word: opcode [IW-1:IW-3], Rx [2*RB-1:RB], Ry [RB-1:0].
REQ-007 G_zero  in  1  high when datapath register G equals zero.
REQ-008 IRin  out  1  loads instruction register / internal IR copy.
REQ-009 Rin  out  NREG  one-hot write enable for R0..R(NREG-1).
REQ-010 Rout  out  NREG  one-hot bus-drive select for R0..R(NREG-1).
REQ-011 Ain, Gin, Gout, DINout  out  1 each  load A, load G, G drives bus, DIN drives bus.
REQ-012 Ulaop  out  2  ALU op: 00 add, 01 sub, 10 and, 11 set-less-than.
REQ-013 Done  out  1  one-cycle pulse in the final step of every instruction.
REQ-014 Tstep  out  2  current step (T0..T3); Busy  out  1  high in any state except IDLE.

Function
REQ-015 FSM states: IDLE, T0, T1, T2, T3; state and IR copy are the only flops besides Done-related decode.
REQ-016 IDLE -> T0 when Run=1; otherwise remain IDLE.
REQ-017 T0: IRin=1; internal IR copy captures Instrucao on the T0->T1 edge; all later steps decode the copy only.
REQ-018 Outputs are combinational decode of (state, IR copy, G_zero); every output not listed for a step is 0.
REQ-019 Opcode 000 mv: T1 Rout[Ry]=1, Rin[Rx]=1, Done=1.
REQ-020 Opcode 001 mvi: T1 DINout=1, Rin[Rx]=1, Done=1.
REQ-021 Opcodes 010 add, 011 sub, 101 and, 110 slt: T1 Rout[Rx]=1, Ain=1; T2 Rout[Ry]=1, Gin=1, Ulaop=00/01/10/11 respectively; T3 Gout=1, Rin[Rx]=1, Done=1.
REQ-022 Opcode 100 mvnz: T1 Done=1; if G_zero=0, Rout[Ry]=1 and Rin[Rx]=1; if G_zero=1, Rin and Rout stay all-zero (no self-copy).
REQ-023 Opcode 111 reserved: T1 Done=1 only, no datapath enables (NOP).
REQ-024 Step after Done: T0 if Run=1 (back-to-back, no idle cycle), else IDLE.
REQ-025 Rin and Rout are one-hot or zero at all times; never more than one bit set.
REQ-026 Latency: mv/mvi/mvnz/NOP 2 cycles from T0 entry to Done; ALU ops 4 cycles.
REQ-027 Run changes while Busy=1 and not in the final step are ignored; instruction always completes.
REQ-028 Instrucao changes after T0 have no effect on the running instruction.
REQ-029 Tstep encoding: T0=00, T1=01, T2=10, T3=11; in IDLE Tstep=00 with Busy=0.

Reset
REQ-030 Resetn=0 forces state IDLE and IR copy to 0 immediately, independent of Clock.
REQ-031 During and after reset until next start: all outputs 0 (Tstep=00, Busy=0, Done=0).
REQ-032 Reset mid-instruction aborts it with no Done and no further enables; first rising edge after Resetn=1 with Run=1 enters T0.

Verification
REQ-033 Reset, Run=1, Instrucao=001_010_000 (mvi R2) -> T0 IRin=1; T1 DINout=1, Rin=00000100, Done=1; then IDLE if Run=0.
REQ-034 Instrucao=011_001_011 (sub R1,R3) -> T1 Rout=00000010, Ain=1; T2 Rout=00001000, Gin=1, Ulaop=01; T3 Gout=1, Rin=00000010, Done=1.
REQ-035 mvnz 100_000_101 with G_zero=0 -> T1 Rout=00100000, Rin=00000001, Done=1; repeat with G_zero=1 -> Rin=Rout=0, Done=1.
REQ-036 Run held 1 across mv then add -> add's T0 follows mv's Done cycle directly; Instrucao changed at add T2 does not alter T3 enables.
REQ-037 Resetn pulsed low during add T2 -> Gin drops to 0 asynchronously, no Done, Busy=0; restart executes normally.
REQ-038 NREG=16 build, Instrucao=010_1111_0000 (add R15,R0) -> T1 Rout bit 15, T2 Rout bit 0, T3 Rin bit 15; opcode 111 -> Done at T1, no enables.

Source files
------------

// File: rtl/unidade_controle_multiciclo.sv
// rtl/unidade_controle_multiciclo.sv - multi-cycle processor control unit (IDLE/T0..T3 FSM)
//
// Purpose: sequences a small multi-cycle datapath. An instruction is latched
// into an internal IR copy at the end of T0. Every later step decodes only that
// copy, so Instrucao may change freely once T0 is over.
//
// Ports:
//   Clock      rising-edge clock
//   Resetn     asynchronous active-low reset
//   Run        start request (sampled in IDLE and in the final step)
//   Instrucao  instruction word {opcode[2:0], Rx[RB-1:0], Ry[RB-1:0]}
//   G_zero     datapath register G equals zero
//   IRin       load instruction register (T0)
//   Rin        one-hot register write enable
//   Rout       one-hot register bus-drive select
//   Ain, Gin   load A / load G
//   Gout       G drives the bus
//   DINout     DIN drives the bus
//   Ulaop      ALU op: 00 add, 01 sub, 10 and, 11 slt
//   Done       one-cycle pulse in the final step of each instruction
//   Tstep      current step T0..T3 (00 in IDLE)
//   Busy       high in any state except IDLE
module unidade_controle_multiciclo #(
   parameter int NREG = 8,
   parameter int RB   = $clog2(NREG),
   localparam int IW  = 3 + 2*RB
) (
   input  logic            Clock,
   input  logic            Resetn,
   input  logic            Run,
   input  logic [IW-1:0]   Instrucao,
   input  logic            G_zero,
   output logic            IRin,
   output logic [NREG-1:0] Rin,
   output logic [NREG-1:0] Rout,
   output logic            Ain,
   output logic            Gin,
   output logic            Gout,
   output logic            DINout,
   output logic [1:0]      Ulaop,
   output logic            Done,
   output logic [1:0]      Tstep,
   output logic            Busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T2,
      S_T3
   } state_t;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MVNZ = 3'b100;
   localparam logic [2:0] OP_AND  = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;

   localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] ir;

   logic [2:0]    opcode;
   logic [RB-1:0] rx;
   logic [RB-1:0] ry;
   logic          is_alu;
   logic [1:0]    alu_op;
   // Final-step continuation shared by every instruction: back-to-back on Run.
   state_t        after_done;

   assign opcode     = ir[IW-1:IW-3];
   assign rx         = ir[2*RB-1:RB];
   assign ry         = ir[RB-1:0];
   assign after_done = Run ? S_T0 : S_IDLE;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= S_IDLE;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_T0) begin
            ir <= Instrucao;
         end
      end
   end

   always_comb begin
      is_alu = 1'b0;
      alu_op = 2'b00;
      case (opcode)
         OP_ADD:  begin is_alu = 1'b1; alu_op = 2'b00; end
         OP_SUB:  begin is_alu = 1'b1; alu_op = 2'b01; end
         OP_AND:  begin is_alu = 1'b1; alu_op = 2'b10; end
         OP_SLT:  begin is_alu = 1'b1; alu_op = 2'b11; end
         default: begin is_alu = 1'b0; alu_op = 2'b00; end
      endcase
   end

   always_comb begin
      state_nxt = state;
      IRin      = 1'b0;
      Rin       = '0;
      Rout      = '0;
      Ain       = 1'b0;
      Gin       = 1'b0;
      Gout      = 1'b0;
      DINout    = 1'b0;
      Ulaop     = 2'b00;
      Done      = 1'b0;
      Tstep     = 2'b00;
      Busy      = 1'b0;

      case (state)
         S_IDLE: begin
            if (Run) begin
               state_nxt = S_T0;
            end
         end

         S_T0: begin
            Busy      = 1'b1;
            Tstep     = 2'b00;
            IRin      = 1'b1;
            state_nxt = S_T1;
         end

         S_T1: begin
            Busy  = 1'b1;
            Tstep = 2'b01;
            if (is_alu) begin
               Rout      = ONE << rx;
               Ain       = 1'b1;
               state_nxt = S_T2;
            end else begin
               Done      = 1'b1;
               state_nxt = after_done;
               case (opcode)
                  OP_MV: begin
                     Rout = ONE << ry;
                     Rin  = ONE << rx;
                  end
                  OP_MVI: begin
                     DINout = 1'b1;
                     Rin    = ONE << rx;
                  end
                  OP_MVNZ: begin
                     // Conditional move; with G=0 nothing moves at all.
                     if (!G_zero) begin
                        Rout = ONE << ry;
                        Rin  = ONE << rx;
                     end
                  end
                  default: begin
                     // Reserved opcode: NOP, Done only.
                  end
               endcase
            end
         end

         S_T2: begin
            Busy      = 1'b1;
            Tstep     = 2'b10;
            Rout      = ONE << ry;
            Gin       = 1'b1;
            Ulaop     = alu_op;
            state_nxt = S_T3;
         end

         S_T3: begin
            Busy      = 1'b1;
            Tstep     = 2'b11;
            Gout      = 1'b1;
            Rin       = ONE << rx;
            Done      = 1'b1;
            state_nxt = after_done;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// tb/tb_unidade_controle_multiciclo.sv - table-driven bench for unidade_controle_multiciclo
module tb_unidade_controle_multiciclo;

   logic        Clock;
   logic        Resetn;

   logic        Run;
   logic [8:0]  Instrucao;
   logic        G_zero;
   logic        IRin, Ain, Gin, Gout, DINout, Done, Busy;
   logic [7:0]  Rin, Rout;
   logic [1:0]  Ulaop, Tstep;

   logic        run16;
   logic [10:0] instr16;
   logic        gz16;
   logic        irin16, ain16, gin16, gout16, din16, done16, busy16;
   logic [15:0] rin16, rout16;
   logic [1:0]  ulaop16, tstep16;

   int n_checks;
   int n_fail;

   unidade_controle_multiciclo #(.NREG(8)) dut (
      .Clock(Clock), .Resetn(Resetn), .Run(Run), .Instrucao(Instrucao),
      .G_zero(G_zero), .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain),
      .Gin(Gin), .Gout(Gout), .DINout(DINout), .Ulaop(Ulaop), .Done(Done),
      .Tstep(Tstep), .Busy(Busy)
   );

   unidade_controle_multiciclo #(.NREG(16)) dut16 (
      .Clock(Clock), .Resetn(Resetn), .Run(run16), .Instrucao(instr16),
      .G_zero(gz16), .IRin(irin16), .Rin(rin16), .Rout(rout16), .Ain(ain16),
      .Gin(gin16), .Gout(gout16), .DINout(din16), .Ulaop(ulaop16), .Done(done16),
      .Tstep(tstep16), .Busy(busy16)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic        run;
      logic [8:0]  instr;
      logic        gz;
      logic [26:0] exp;
   } row_t;

   row_t vec[$];

   function automatic logic [26:0] mk(input logic busy, input logic [1:0] t, input logic irin,
                                      input logic [7:0] rin, input logic [7:0] rout,
                                      input logic ain, input logic gin, input logic gout,
                                      input logic din, input logic [1:0] op, input logic done);
      return {busy, t, irin, rin, rout, ain, gin, gout, din, op, done};
   endfunction

   function automatic logic [42:0] mk16(input logic busy, input logic [1:0] t, input logic irin,
                                        input logic [15:0] rin, input logic [15:0] rout,
                                        input logic ain, input logic gin, input logic gout,
                                        input logic din, input logic [1:0] op, input logic done);
      return {busy, t, irin, rin, rout, ain, gin, gout, din, op, done};
   endfunction

   function automatic logic [26:0] act8();
      return {Busy, Tstep, IRin, Rin, Rout, Ain, Gin, Gout, DINout, Ulaop, Done};
   endfunction

   function automatic logic [42:0] act16();
      return {busy16, tstep16, irin16, rin16, rout16, ain16, gin16, gout16, din16, ulaop16, done16};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_row(input logic run, input logic [8:0] instr, input logic gz,
                          input logic [26:0] exp);
      row_t r;
      r.run = run; r.instr = instr; r.gz = gz; r.exp = exp;
      vec.push_back(r);
   endtask

   task automatic step();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   logic [26:0] s_idle;
   logic [26:0] s_t0;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      Resetn = 1'b0; Run = 1'b0; Instrucao = '0; G_zero = 1'b0;
      run16 = 1'b0; instr16 = '0; gz16 = 1'b0;

      s_idle = mk(0, 2'd0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0);
      s_t0   = mk(1, 2'd0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0);

      // mvi R2, then Run=0 -> IDLE; Instrucao changed after T0 must not matter
      add_row(1, 9'b001_010_000, 0, s_idle);
      add_row(0, 9'b001_010_000, 0, s_t0);
      add_row(0, 9'b000_000_000, 0, mk(1, 2'd1, 0, 8'h04, 8'h00, 0, 0, 0, 1, 2'd0, 1));
      // sub R1,R3 then back-to-back mvnz
      add_row(1, 9'b011_001_011, 0, s_idle);
      add_row(0, 9'b011_001_011, 0, s_t0);
      add_row(0, 9'b111_111_111, 0, mk(1, 2'd1, 0, 8'h00, 8'h02, 1, 0, 0, 0, 2'd0, 0));
      add_row(0, 9'b111_111_111, 0, mk(1, 2'd2, 0, 8'h00, 8'h08, 0, 1, 0, 0, 2'd1, 0));
      add_row(1, 9'b100_000_101, 0, mk(1, 2'd3, 0, 8'h02, 8'h00, 0, 0, 1, 0, 2'd0, 1));
      // mvnz R0,R5 with G_zero=0, then again with G_zero=1
      add_row(0, 9'b100_000_101, 0, s_t0);
      add_row(1, 9'b100_000_101, 0, mk(1, 2'd1, 0, 8'h01, 8'h20, 0, 0, 0, 0, 2'd0, 1));
      add_row(0, 9'b100_000_101, 1, s_t0);
      add_row(1, 9'b000_011_100, 1, mk(1, 2'd1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 1));
      // mv R3,R4 with Run held, then add R2,R6 directly after
      add_row(1, 9'b000_011_100, 0, s_t0);
      add_row(1, 9'b010_010_110, 0, mk(1, 2'd1, 0, 8'h08, 8'h10, 0, 0, 0, 0, 2'd0, 1));
      add_row(0, 9'b010_010_110, 0, s_t0);
      add_row(0, 9'b010_010_110, 0, mk(1, 2'd1, 0, 8'h00, 8'h04, 1, 0, 0, 0, 2'd0, 0));
      add_row(0, 9'b001_111_111, 0, mk(1, 2'd2, 0, 8'h00, 8'h40, 0, 1, 0, 0, 2'd0, 0));
      add_row(1, 9'b101_001_010, 0, mk(1, 2'd3, 0, 8'h04, 8'h00, 0, 0, 1, 0, 2'd0, 1));
      // and R1,R2 with Run raised mid-instruction
      add_row(0, 9'b101_001_010, 0, s_t0);
      add_row(0, 9'b101_001_010, 0, mk(1, 2'd1, 0, 8'h00, 8'h02, 1, 0, 0, 0, 2'd0, 0));
      add_row(1, 9'b101_001_010, 0, mk(1, 2'd2, 0, 8'h00, 8'h04, 0, 1, 0, 0, 2'd2, 0));
      add_row(1, 9'b110_011_000, 0, mk(1, 2'd3, 0, 8'h02, 8'h00, 0, 0, 1, 0, 2'd0, 1));
      // slt R3,R0 then reserved opcode
      add_row(0, 9'b110_011_000, 0, s_t0);
      add_row(0, 9'b110_011_000, 0, mk(1, 2'd1, 0, 8'h00, 8'h08, 1, 0, 0, 0, 2'd0, 0));
      add_row(0, 9'b110_011_000, 0, mk(1, 2'd2, 0, 8'h00, 8'h01, 0, 1, 0, 0, 2'd3, 0));
      add_row(1, 9'b111_101_101, 0, mk(1, 2'd3, 0, 8'h08, 8'h00, 0, 0, 1, 0, 2'd0, 1));
      add_row(0, 9'b111_101_101, 0, s_t0);
      add_row(0, 9'b111_101_101, 0, mk(1, 2'd1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 1));
      add_row(0, 9'b111_101_101, 0, s_idle);
      add_row(0, 9'b111_101_101, 0, s_idle);

      // reset state
      #12;
      check("reset8", 64'(act8()), 64'(s_idle));
      check("reset16", 64'(act16()), 64'h0);
      @(negedge Clock);
      Resetn = 1'b1;

      foreach (vec[i]) begin
         Run = vec[i].run; Instrucao = vec[i].instr; G_zero = vec[i].gz;
         #1;
         check($sformatf("row%0d", i), 64'(act8()), 64'(vec[i].exp));
         step();
      end

      // reset pulsed during add T2
      Run = 1'b1; Instrucao = 9'b010_001_010; G_zero = 1'b0;
      step();
      Run = 1'b0;
      step();
      step();
      #1;
      check("abort_t2_pre", 64'(act8()), 64'(mk(1, 2'd2, 0, 8'h00, 8'h04, 0, 1, 0, 0, 2'd0, 0)));
      #1;
      Resetn = 1'b0;
      #1;
      check("abort_async", 64'(act8()), 64'(s_idle));
      @(posedge Clock);
      #1;
      check("abort_held", 64'(act8()), 64'(s_idle));
      @(negedge Clock);
      Resetn = 1'b1;
      Run = 1'b1; Instrucao = 9'b001_110_000;
      #1;
      check("restart_idle", 64'(act8()), 64'(s_idle));
      step();
      Run = 1'b0;
      #1;
      check("restart_t0", 64'(act8()), 64'(s_t0));
      step();
      #1;
      check("restart_t1", 64'(act8()), 64'(mk(1, 2'd1, 0, 8'h40, 8'h00, 0, 0, 0, 1, 2'd0, 1)));
      step();
      #1;
      check("restart_idle2", 64'(act8()), 64'(s_idle));

      // 16-register build: add R15,R0 then reserved opcode
      run16 = 1'b1; instr16 = 11'b010_1111_0000;
      step();
      run16 = 1'b0;
      #1;
      check("n16_t0", 64'(act16()), 64'(mk16(1, 2'd0, 1, 16'h0, 16'h0, 0, 0, 0, 0, 2'd0, 0)));
      step();
      instr16 = 11'b111_0000_0000;
      #1;
      check("n16_t1", 64'(act16()), 64'(mk16(1, 2'd1, 0, 16'h0, 16'h8000, 1, 0, 0, 0, 2'd0, 0)));
      step();
      #1;
      check("n16_t2", 64'(act16()), 64'(mk16(1, 2'd2, 0, 16'h0, 16'h0001, 0, 1, 0, 0, 2'd0, 0)));
      step();
      run16 = 1'b1;
      #1;
      check("n16_t3", 64'(act16()), 64'(mk16(1, 2'd3, 0, 16'h8000, 16'h0, 0, 0, 1, 0, 2'd0, 1)));
      step();
      run16 = 1'b0;
      #1;
      check("n16_nop_t0", 64'(act16()), 64'(mk16(1, 2'd0, 1, 16'h0, 16'h0, 0, 0, 0, 0, 2'd0, 0)));
      step();
      #1;
      check("n16_nop_t1", 64'(act16()), 64'(mk16(1, 2'd1, 0, 16'h0, 16'h0, 0, 0, 0, 0, 2'd0, 1)));
      step();
      #1;
      check("n16_idle", 64'(act16()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
